// File: rtl/playback_sample_stepper.sv
// playback_sample_stepper
//   Turns the DAC's per-sample tick into SRAM read addresses and output
//   samples. Playback runs at normal speed, fast speed (skip N-1 samples per
//   tick) or slow speed (each sample held for N ticks). Mode and N are latched
//   when start is accepted.
//
//   Optional feature macro: PLAYBACK_INTERP_EN
//     defined   - slow mode fetches the next sample too, and outputs a linear
//                 interpolation between the two across the N ticks
//     undefined - slow mode holds the fetched sample for N ticks
//
// Ports
//   clk50, rst_n           clock, asynchronous active-low reset
//   sample_tick            DAC wants the next sample (1-cycle strobe)
//   start / stop / pause   playback control (start/stop strobes, pause level)
//   is_normal, is_fast     speed select, is_normal has priority
//   ratio                  speed factor N = ratio + 1
//   end_addr               last valid sample address (inclusive)
//   rd_req/rd_addr         SRAM read request, address held while requesting
//   rd_ack/rd_data         read completion, data valid with ack
//   sample_out/valid       output sample and its 1-cycle update pulse
//   playing, done          playback active level, end-of-playback pulse
//   underrun               sticky: a tick arrived while a read was in flight
module playback_sample_stepper #(
    parameter int AW = 20,
    parameter int DW = 16
) (
    input  logic          clk50,
    input  logic          rst_n,
    input  logic          sample_tick,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          is_normal,
    input  logic          is_fast,
    input  logic [2:0]    ratio,
    input  logic [AW-1:0] end_addr,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_ack,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] sample_out,
    output logic          sample_valid,
    output logic          playing,
    output logic          done,
    output logic          underrun
);

`ifdef PLAYBACK_INTERP_EN
    localparam bit INTERP = 1'b1;
`else
    localparam bit INTERP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B, WAIT_TICK} state_t;
    typedef enum logic [1:0] {M_NORMAL, M_FAST, M_SLOW} mode_t;

    state_t state, state_nx;
    mode_t  mode;

    logic [2:0]           nm1;       // latched ratio (N-1)
    logic [2:0]           phase;
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] samp_a;
    logic signed [DW-1:0] samp_nx;
    logic                 b_gap;     // one idle request cycle between the A and B reads
    logic                 fin;       // last sample emitted, done pulse follows next cycle
    logic [3:0]           n_val;
    logic [AW:0]          step_sum;  // one bit wider so the end check cannot wrap
    logic                 over;
    logic                 last_b;
    logic                 tick_go;
    logic                 adv;

    // ---------------- state register ----------------
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // ---------------- next state / read port ----------------
    always_comb begin
        state_nx = state;
        rd_req   = 1'b0;
        rd_addr  = addr;
        tick_go  = 1'b0;
        adv      = 1'b0;
        n_val    = {1'b0, nm1} + 4'd1;
        if (mode == M_FAST) step_sum = {1'b0, addr} + {{(AW-3){1'b0}}, n_val};
        else                step_sum = {1'b0, addr} + {{AW{1'b0}}, 1'b1};
        over     = step_sum > {1'b0, end_addr};
        last_b   = (addr == end_addr);

        case (state)
            IDLE: begin
                if (start) state_nx = FETCH_A;
            end
            FETCH_A: begin
                rd_req = 1'b1;
                if (rd_ack) state_nx = (INTERP && mode == M_SLOW) ? FETCH_B : WAIT_TICK;
            end
            FETCH_B: begin
                rd_addr = addr + AW'(1);
                // At the final address there is no successor to read.
                if (last_b) state_nx = WAIT_TICK;
                else begin
                    rd_req = !b_gap;
                    if (rd_ack && !b_gap) state_nx = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (fin) state_nx = IDLE;
                else if (sample_tick && !pause) begin
                    tick_go = 1'b1;
                    adv     = (mode != M_SLOW) || (phase == nm1);
                    if (adv && !over) state_nx = FETCH_A;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (stop) state_nx = IDLE;
    end

    // ---------------- output sample selection ----------------
`ifdef PLAYBACK_INTERP_EN
    localparam int PW = DW + 17;
    localparam logic signed [PW-1:0] SMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [DW-1:0] samp_b;
    logic signed [DW:0]   diff;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] interp;
    logic [12:0]          recip;

    always_comb begin
        // round(4096/N)
        recip = 13'd4096;
        case (nm1)
            3'd0: recip = 13'd4096;
            3'd1: recip = 13'd2048;
            3'd2: recip = 13'd1365;
            3'd3: recip = 13'd1024;
            3'd4: recip = 13'd819;
            3'd5: recip = 13'd683;
            3'd6: recip = 13'd585;
            3'd7: recip = 13'd512;
            default: recip = 13'd4096;
        endcase
        diff   = {samp_b[DW-1], samp_b} - {samp_a[DW-1], samp_a};
        prod   = PW'(diff) * PW'($signed({1'b0, phase})) * PW'($signed({1'b0, recip}));
        interp = PW'(samp_a) + (prod >>> 12);
        samp_nx = samp_a;
        if (mode == M_SLOW) begin
            if (interp > SMAX)      samp_nx = SMAX[DW-1:0];
            else if (interp < SMIN) samp_nx = SMIN[DW-1:0];
            else                    samp_nx = interp[DW-1:0];
        end
    end
`else
    assign samp_nx = samp_a;
`endif

    // ---------------- datapath / status registers ----------------
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            mode         <= M_NORMAL;
            nm1          <= 3'd0;
            phase        <= 3'd0;
            addr         <= '0;
            samp_a       <= '0;
`ifdef PLAYBACK_INTERP_EN
            samp_b       <= '0;
`endif
            b_gap        <= 1'b0;
            fin          <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            playing      <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            b_gap        <= (state == FETCH_A) && rd_ack;
            if (stop) begin
                playing <= 1'b0;
                fin     <= 1'b0;
                b_gap   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            addr     <= '0;
                            phase    <= 3'd0;
                            underrun <= 1'b0;
                            playing  <= 1'b1;
                            nm1      <= ratio;
                            if (is_normal)    mode <= M_NORMAL;
                            else if (is_fast) mode <= M_FAST;
                            else              mode <= M_SLOW;
                        end
                    end
                    FETCH_A: begin
                        if (sample_tick && !pause) underrun <= 1'b1;
                        if (rd_ack) samp_a <= rd_data;
                    end
                    FETCH_B: begin
                        if (sample_tick && !pause) underrun <= 1'b1;
`ifdef PLAYBACK_INTERP_EN
                        if (last_b)                samp_b <= samp_a;
                        else if (rd_ack && !b_gap) samp_b <= rd_data;
`endif
                    end
                    WAIT_TICK: begin
                        if (fin) begin
                            done    <= 1'b1;
                            playing <= 1'b0;
                            fin     <= 1'b0;
                        end else if (tick_go) begin
                            sample_out   <= samp_nx;
                            sample_valid <= 1'b1;
                            if (adv) begin
                                phase <= 3'd0;
                                if (over) fin  <= 1'b1;
                                else      addr <= step_sum[AW-1:0];
                            end else begin
                                phase <= phase + 3'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_playback_sample_stepper.sv
// Scoreboard bench for playback_sample_stepper: expected sample streams are
// derived from the playback rules per mode and queued at start; a monitor
// pops one entry per sample_valid. An SRAM responder serves reads with a
// configurable latency.
module tb_playback_sample_stepper;
    localparam int AW = 20;
    localparam int DW = 16;
`ifdef PLAYBACK_INTERP_EN
    localparam bit TB_INTERP = 1'b1;
`else
    localparam bit TB_INTERP = 1'b0;
`endif

    logic          clk50 = 1'b0;
    logic          rst_n;
    logic          sample_tick, start, stop, pause, is_normal, is_fast;
    logic [2:0]    ratio;
    logic [AW-1:0] end_addr;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] sample_out;
    logic          sample_valid, playing, done, underrun;

    playback_sample_stepper #(.AW(AW), .DW(DW)) dut (
        .clk50(clk50), .rst_n(rst_n), .sample_tick(sample_tick), .start(start),
        .stop(stop), .pause(pause), .is_normal(is_normal), .is_fast(is_fast),
        .ratio(ratio), .end_addr(end_addr), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .sample_out(sample_out),
        .sample_valid(sample_valid), .playing(playing), .done(done), .underrun(underrun)
    );

    always #5 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc++;

    logic signed [15:0] mem [64];
    logic [DW-1:0]      exp_q[$];
    logic [AW-1:0]      rd_log[$];
    int checks = 0, failures = 0;
    int valid_cnt = 0, done_cnt = 0, last_valid_cyc = 0, done_cyc = 0;
    int lat_min = 2, lat_max = 2;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected slow-mode output for address a, phase p, factor n.
    function automatic logic [15:0] slow_val(input int a, input int e, input int p, input int n);
        longint va, vb, prod, v;
        int recip;
        va = longint'(mem[a]);
        vb = (a == e) ? va : longint'(mem[a+1]);
        recip = (4096 + n/2) / n;
        prod = (vb - va) * p * recip;
        v = va + (prod >>> 12);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        if (!TB_INTERP) v = va;
        return v[15:0];
    endfunction

    // m: 0 normal, 1 fast, 2 slow
    task automatic push_expected(input int m, input int n, input int e);
        int a;
        a = 0;
        while (a <= e) begin
            if (m == 0) begin exp_q.push_back(mem[a]); a += 1; end
            else if (m == 1) begin exp_q.push_back(mem[a]); a += n; end
            else begin
                for (int p = 0; p < n; p++) exp_q.push_back(slow_val(a, e, p, n));
                a += 1;
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk50) begin
        if (sample_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_sample got=%0d expected=none t=%0t", $signed(sample_out), $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                chk("sample_out", $signed(sample_out), $signed(e));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- SRAM responder ----------------
    initial begin : resp
        logic [AW-1:0] ra;
        int lat;
        rd_ack = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk50);
            if (rd_req && rst_n) begin
                ra  = rd_addr;
                lat = $urandom_range(lat_max, lat_min);
                repeat (lat - 1) @(negedge clk50);
                if (rd_req) chk("rd_addr_stable", rd_addr, ra);
                rd_log.push_back(ra);
                rd_ack  = 1'b1;
                rd_data = mem[ra[5:0]];
                @(negedge clk50);
                rd_ack  = 1'b0;
                chk("rd_req_drop", rd_req, 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_play(input int m, input int r, input int e);
        is_normal = (m == 0);
        is_fast   = (m == 1) ? 1'b1 : ((m == 0) ? 1'($urandom_range(1)) : 1'b0);
        ratio     = 3'(r);
        end_addr  = AW'(e);
        push_expected(m, r + 1, e);
        @(negedge clk50); start = 1'b1;
        @(negedge clk50); start = 1'b0;
        chk("playing_after_start", playing, 1);
        // mode inputs must be ignored once playback runs
        is_normal = 1'($urandom_range(1));
        is_fast   = 1'($urandom_range(1));
        ratio     = 3'($urandom_range(7));
    endtask

    task automatic drive_to_done(input int period, input bit pause_en);
        int d0, budget;
        d0 = done_cnt;
        budget = 8000;
        while (done_cnt == d0 && budget > 0) begin
            repeat (period - 1) @(negedge clk50);
            budget -= period;
            pause = pause_en && ($urandom_range(3) == 0);
            sample_tick = 1'b1;
            @(negedge clk50);
            sample_tick = 1'b0;
            pause = 1'b0;
        end
        chk("done_seen", longint'(done_cnt != d0), 1);
        chk("done_after_valid", done_cyc - last_valid_cyc, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("playing_low", playing, 0);
        exp_q.delete();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    endtask

    // ---------------- main ----------------
    initial begin
        int vc, dc;
        rst_n = 1'b0; sample_tick = 0; start = 0; stop = 0; pause = 0;
        is_normal = 0; is_fast = 0; ratio = 0; end_addr = '0;
        fill_random();
        repeat (3) @(negedge clk50);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_playing", playing, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk50);

        // Normal speed, mem[i] = i*100
        for (int i = 0; i < 4; i++) mem[i] = 16'(i * 100);
        start_play(0, 0, 3);
        drive_to_done(10, 0);

        // Fast N=3 up to 9: reads at 0,3,6,9
        fill_random();
        rd_log.delete();
        start_play(1, 2, 9);
        drive_to_done(8, 0);
        chk("fast_read_count", rd_log.size(), 4);
        for (int k = 0; k < 4 && k < rd_log.size(); k++) chk("fast_read_addr", rd_log[k], 3 * k);

        // Slow N=4, 0 -> 400
        mem[0] = 16'sd0; mem[1] = 16'sd400;
        start_play(2, 3, 1);
        drive_to_done(10, 0);

        // Tick during a long read -> underrun, no output for it
        fill_random();
        lat_min = 8; lat_max = 8;
        start_play(0, 0, 2);
        vc = valid_cnt;
        sample_tick = 1'b1; @(negedge clk50); sample_tick = 1'b0;
        @(negedge clk50);
        chk("underrun_set", underrun, 1);
        chk("dropped_tick_no_valid", valid_cnt, vc);
        lat_min = 2; lat_max = 2;
        drive_to_done(10, 0);
        chk("underrun_sticky", underrun, 1);
        start_play(0, 0, 1);
        chk("underrun_cleared", underrun, 0);
        drive_to_done(10, 0);

        // Stop while a read is outstanding
        lat_min = 8; lat_max = 8;
        start_play(0, 0, 10);
        chk("stop_pre_req", rd_req, 1);
        stop = 1'b1; @(negedge clk50); stop = 1'b0;
        chk("stop_rd_req", rd_req, 0);
        chk("stop_playing", playing, 0);
        exp_q.delete();
        vc = valid_cnt; dc = done_cnt;
        repeat (20) @(negedge clk50);
        chk("stop_no_valid", valid_cnt, vc);
        chk("stop_no_done", done_cnt, dc);
        lat_min = 2; lat_max = 2;

        // Pause across 3 ticks while waiting at address 1
        fill_random();
        start_play(0, 0, 5);
        repeat (6) @(negedge clk50);
        sample_tick = 1'b1; @(negedge clk50); sample_tick = 1'b0;
        repeat (6) @(negedge clk50);
        pause = 1'b1;
        vc = valid_cnt;
        repeat (3) begin
            repeat (3) @(negedge clk50);
            sample_tick = 1'b1; @(negedge clk50); sample_tick = 1'b0;
        end
        repeat (2) @(negedge clk50);
        chk("pause_no_valid", valid_cnt, vc);
        chk("pause_rd_addr", rd_addr, 1);
        chk("pause_no_req", rd_req, 0);
        pause = 1'b0;
        drive_to_done(8, 0);

        // Randomized playbacks
        for (int run = 0; run < 10; run++) begin
            fill_random();
            lat_min = 1; lat_max = 4;
            start_play($urandom_range(2), $urandom_range(7), $urandom_range(15));
            drive_to_done($urandom_range(12, 5), 1);
        end

        repeat (5) @(negedge clk50);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
